// File: rtl/tile_pkg.sv
// Shared types and tile geometry for the tile fetch controller.
package tile_pkg;

  localparam int TileRows      = 4;
  localparam int TileCols      = 4;
  localparam int TileElemWidth = 8;
  localparam int TileElems     = TileRows * TileCols;
  localparam int TileBits      = TileElems * TileElemWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tile_fsm_e;

endpackage

// File: rtl/tile_fetch_ctrl_if.sv
// Memory read port plus the downstream tile stream of the fetch controller.
interface tile_fetch_ctrl_if #(
  parameter int AddrWidth = 10,
  parameter int DimWidth  = 7,
  parameter int DataWidth = 128
);

  logic [AddrWidth-1:0] mem_addr_o;
  logic [DimWidth-1:0]  mem_col_o;
  logic [DataWidth-1:0] mem_rd_data_i;
  logic                 tile_valid_o;
  logic                 tile_ready_i;
  logic [DataWidth-1:0] tile_data_o;
  logic [DimWidth-1:0]  tile_row_o;
  logic [DimWidth-1:0]  tile_col_o;
  logic                 tile_last_o;

  modport master (
    output mem_addr_o, mem_col_o,
    input  mem_rd_data_i,
    output tile_valid_o, tile_data_o, tile_row_o, tile_col_o, tile_last_o,
    input  tile_ready_i
  );

  modport slave (
    input  mem_addr_o, mem_col_o,
    output mem_rd_data_i,
    input  tile_valid_o, tile_data_o, tile_row_o, tile_col_o, tile_last_o,
    output tile_ready_i
  );

endinterface

// File: rtl/tile_addr_gen.sv
// Tile row/column walker and top-left element address arithmetic.
module tile_addr_gen
  import tile_pkg::*;
#(
  parameter int DataRows    = TileRows,
  parameter int DataColumns = TileCols,
  parameter int AddrWidth   = 10,
  parameter int DimWidth    = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [DimWidth-1:0]  stride_i,
  input  logic [DimWidth-1:0]  rows_i,
  input  logic [DimWidth-1:0]  cols_i,
  output logic [DimWidth-1:0]  tr_o,
  output logic [DimWidth-1:0]  tc_o,
  output logic                 last_o,
  output logic [AddrWidth-1:0] addr_o
);

  localparam int ProdRaw = 2 * DimWidth + 8;
  localparam int ProdW   = (ProdRaw > AddrWidth) ? ProdRaw : AddrWidth;

  logic [DimWidth-1:0] tr_q, tc_q;
  logic                tc_wrap;
  logic [ProdW-1:0]    row_off, col_off;

  assign tc_wrap = (tc_q == cols_i - DimWidth'(1));
  assign last_o  = tc_wrap && (tr_q == rows_i - DimWidth'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tr_q <= '0;
      tc_q <= '0;
    end else if (clear_i) begin
      tr_q <= '0;
      tc_q <= '0;
    end else if (advance_i) begin
      if (tc_wrap) begin
        tc_q <= '0;
        tr_q <= tr_q + DimWidth'(1);
      end else begin
        tc_q <= tc_q + DimWidth'(1);
      end
    end
  end

  // Offsets are formed wide and truncated, so the address wraps modulo 2^AddrWidth.
  always_comb begin
    row_off = ProdW'(tr_q) * ProdW'(stride_i) * ProdW'(DataRows);
    col_off = ProdW'(tc_q) * ProdW'(DataColumns);
    addr_o  = base_i + row_off[AddrWidth-1:0] + col_off[AddrWidth-1:0];
  end

  assign tr_o = tr_q;
  assign tc_o = tc_q;

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Read-side tile fetch controller: walks a row-major matrix tile by tile and
// streams each combinationally read tile downstream over valid/ready.
//
// state | meaning
// IDLE  | waiting for start_i; config and counters hold
// FETCH | loading one tile per free output slot; an empty job exits to DONE
// DRAIN | final tile loaded, waiting for its handshake
// DONE  | one-cycle done_o pulse, then back to IDLE
module tile_fetch_ctrl
  import tile_pkg::*;
#(
  parameter int DataRows    = TileRows,
  parameter int DataColumns = TileCols,
  parameter int ElemWidth   = TileElemWidth,
  parameter int DataWidth   = ElemWidth * DataRows * DataColumns,
  parameter int AddrWidth   = 10,
  parameter int DimWidth    = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [DimWidth-1:0]  matrix_cols_i,
  input  logic [DimWidth-1:0]  num_tile_rows_i,
  input  logic [DimWidth-1:0]  num_tile_cols_i,
  output logic                 busy_o,
  output logic                 done_o,
  tile_fetch_ctrl_if.master    bus
);

  tile_fsm_e state_q, state_d;

  logic [AddrWidth-1:0] base_q;
  logic [DimWidth-1:0]  stride_q, rows_q, cols_q;

  logic                 valid_q, last_q;
  logic [DataWidth-1:0] data_q;
  logic [DimWidth-1:0]  row_q, col_q;

  logic                 latch, load, advance, job_empty, hs_last;
  logic [DimWidth-1:0]  tr, tc;
  logic                 tile_last;
  logic [AddrWidth-1:0] addr;

  assign job_empty = (rows_q == '0) || (cols_q == '0);
  assign hs_last   = valid_q && bus.tile_ready_i && last_q;
  // The final tile does not advance the walker, so mem_addr_o stays put in DRAIN.
  assign advance   = load && !tile_last;

  tile_addr_gen #(
    .DataRows    (DataRows),
    .DataColumns (DataColumns),
    .AddrWidth   (AddrWidth),
    .DimWidth    (DimWidth)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (latch),
    .advance_i (advance),
    .base_i    (base_q),
    .stride_i  (stride_q),
    .rows_i    (rows_q),
    .cols_i    (cols_q),
    .tr_o      (tr),
    .tc_o      (tc),
    .last_o    (tile_last),
    .addr_o    (addr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Empty jobs detect the zero count one cycle after start, from the latched config.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          latch   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (job_empty) begin
          state_d = DONE;
        end else if (!valid_q || bus.tile_ready_i) begin
          load = 1'b1;
          if (tile_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (hs_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q   <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
    end else if (latch) begin
      base_q   <= base_addr_i;
      stride_q <= matrix_cols_i;
      rows_q   <= num_tile_rows_i;
      cols_q   <= num_tile_cols_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= bus.mem_rd_data_i;
      row_q   <= tr;
      col_q   <= tc;
      last_q  <= tile_last;
    end else if (valid_q && bus.tile_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.mem_addr_o   = addr;
  assign bus.mem_col_o    = stride_q;
  assign bus.tile_valid_o = valid_q;
  assign bus.tile_data_o  = data_q;
  assign bus.tile_row_o   = row_q;
  assign bus.tile_col_o   = col_q;
  assign bus.tile_last_o  = last_q;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: doc/tile_fetch_ctrl.md
Name: tile_fetch_ctrl

Overview:
- Read-side controller for the tile memory (single_port_memory, combinational read).
- Walks a matrix stored row-major at base_addr_i in DataRows x DataColumns tiles, tile order row-major.
- Drives the memory address, captures each combinational read into an output register and streams tiles downstream over valid/ready.
- Sits directly downstream of the memory and upstream of the compute array's operand loader.

Parameters:
- DataRows, 4, tile height in elements.
- DataColumns, 4, tile width in elements.
- ElemWidth, 8, bits per element.
- DataWidth, ElemWidth*DataRows*DataColumns, tile bus width (128).
- AddrWidth, 10, memory element-address width.
- DimWidth, 7, width of matrix-dimension and tile-count fields.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  single-cycle start request; sampled only in IDLE.
- base_addr_i  in  AddrWidth  element address of matrix element (0,0).
- matrix_cols_i  in  DimWidth  row stride in elements; drives memory MatrixCol.
- num_tile_rows_i  in  DimWidth  tiles vertically.
- num_tile_cols_i  in  DimWidth  tiles horizontally.
- mem_addr_o  out  AddrWidth  memory address, top-left element of current tile.
- mem_col_o  out  DimWidth  stride forwarded to memory MatrixCol.
- mem_rd_data_i  in  DataWidth  combinational tile read data.
- tile_valid_o  out  1  output register holds a tile.
- tile_ready_i  in  1  consumer accepts the tile.
- tile_data_o  out  DataWidth  tile; row r at bits [r*ElemWidth*DataColumns +: ElemWidth*DataColumns].
- tile_row_o  out  DimWidth  tile-row index of tile_data_o.
- tile_col_o  out  DimWidth  tile-col index of tile_data_o.
- tile_last_o  out  1  tile_data_o is the final tile of the job.
- busy_o  out  1  high from the cycle after start until done.
- done_o  out  1  one-cycle pulse after the last tile handshake.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. The configuration registers are also cleared.
- On start_i in IDLE:
  - Latch base_addr_i, matrix_cols_i, num_tile_rows_i and num_tile_cols_i.
  - Clear the counters and go to FETCH.
  - If either count is 0, go to DONE instead.
- start_i is ignored outside IDLE.
- mem_addr_o = base + tr*DataRows*cols + tc*DataColumns, computed modulo 2^AddrWidth (wrap, no error).
- mem_col_o always equals the latched stride.
- FETCH, per cycle:
  - Load condition: !tile_valid_o || tile_ready_i.
  - On load: register mem_rd_data_i, tr, tc and last flag; set tile_valid_o.
  - On load, advance tc. On tc wrap, tc = 0 and tr++.
  - When the final tile is loaded, go to DRAIN.
- Stall: when tile_valid_o && !tile_ready_i, hold tile_data_o, indices, tile_last_o and mem_addr_o stable.
- Throughput is one tile per cycle with ready held high.
- Latency: start accepted at cycle 0, address valid cycle 1, first tile_valid_o cycle 2.
- DRAIN: wait for the handshake of the last tile (valid && ready && last). Then clear tile_valid_o and go to DONE.
- DONE: assert done_o for one cycle, then go to IDLE. busy_o is low in IDLE only.
- A handshake in the same cycle as a new load is one transfer: the register is replaced, valid stays 1.
- Zero tiles: no tile_valid_o. done_o is asserted 2 cycles after start.
- Reset mid-job aborts immediately: valid drops, no done_o pulse.
- Memory is never written by this block.

Decomposition:
- Package tile_pkg holds:
  - typedef tile_fsm_e {IDLE, FETCH, DRAIN, DONE};
  - localparams TileElems = DataRows*DataColumns and TileBits.
- Optional sub-module tile_addr_gen holds the tr/tc counters and the address arithmetic, with advance/clear inputs and last/addr outputs. The FSM and output register stay in the top.

Test Plan:
- Basic job: base 0, cols 8, 2x2 tiles, ready=1.
  - mem_addr_o sequence 0, 4, 32, 36.
  - Four consecutive valid cycles starting cycle 2.
  - tile_last_o only on (1,1); done_o at cycle 6.
- Backpressure: same job, ready low for 3 cycles on tile (0,1).
  - tile_data_o and mem_addr_o are held; no tile is lost or duplicated.
  - Totals: 4 handshakes, indices in order.
- Zero-size: num_tile_rows_i=0, num_tile_cols_i=3.
  - No tile_valid_o; done_o pulses exactly once, 2 cycles after start.
- Address wrap: base 1020, cols 16, 1x2 tiles.
  - Addresses 1020 then 0 (wrapped); no stall.
- start_i reasserted during FETCH: ignored; job completes with the original config.
- rst_i asserted mid-job on tile 2: outputs reach 0 asynchronously; a new start then runs the full job correctly from tile (0,0).
